// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves memory freeze, redirect and load-use
// hazards each cycle and keeps saturating stall/flush counters plus a timeout flag.
module hazard_ctrl #(
   parameter int CNT_W     = 32,
   parameter int TIMEOUT   = 255,
   parameter int TIMEOUT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             ex_jump,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             pc_sel_target,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             id_ex_hold,
   output logic             ex_mem_hold,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      REDIRECT   = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_next;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 freeze;
   logic                 redirect;
   logic                 load_use;
   logic                 stall_win;
   logic                 flush_win;

   assign state = state_q;

   // Hazard detection and priority resolution: freeze beats redirect beats load-use.
   always_comb begin
      freeze        = mem_access & ~dmem_ready;
      redirect      = ex_branch_taken | ex_jump;
      load_use      = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));
      pc_write      = 1'b0;
      pc_sel_target = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      id_ex_hold    = 1'b0;
      ex_mem_hold   = 1'b0;
      stall_win     = 1'b0;
      flush_win     = 1'b0;
      state_next    = RUN;
      if (reset) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (freeze) begin
         // Nothing is flushed: the instruction held in EX re-presents afterwards.
         id_ex_hold  = 1'b1;
         ex_mem_hold = 1'b1;
         stall_win   = 1'b1;
         state_next  = MEM_WAIT;
      end else if (redirect) begin
         pc_write      = 1'b1;
         pc_sel_target = 1'b1;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         flush_win     = 1'b1;
         state_next    = REDIRECT;
      end else if (load_use) begin
         id_ex_flush = 1'b1;
         stall_win   = 1'b1;
         state_next  = LOAD_STALL;
      end else begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end
   end

   // State, saturating event counters and the sticky memory timeout monitor.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state_q <= state_next;
         if (stall_win && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush_win && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
         if (freeze) begin
            if (wait_cnt == TIMEOUT_W'(TIMEOUT)) begin
               mem_timeout <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            end
         end else begin
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes model expectations per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

   localparam int CNT_W     = 4;
   localparam int TIMEOUT   = 4;
   localparam int TIMEOUT_W = 3;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic             id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0;
   logic             ex_branch_taken = 0, ex_jump = 0, mem_access = 0, dmem_ready = 0;
   logic             pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_flush;
   logic             id_ex_hold, ex_mem_hold, mem_timeout;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   typedef struct {
      logic [6:0] comb;
      bit         chk_regs;
      int         st;
      int         sc;
      int         fc;
      int         to;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   // Reference model state: what the registered outputs should be right now.
   bit   m_valid = 0;
   int   m_state = 0, m_stall = 0, m_flush = 0, m_wait = 0, m_to = 0;

   hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TIMEOUT_W(TIMEOUT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
      .mem_access(mem_access), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .pc_sel_target(pc_sel_target),
      .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, predicts the cycle's response and advances the model.
   task automatic applyStimulus(input bit rst, input bit [4:0] rs1, input bit [4:0] rs2,
                                input bit u1, input bit u2, input bit [4:0] rd,
                                input bit mr, input bit bt, input bit jp,
                                input bit ma, input bit dr);
      exp_t e;
      bit   f, r, l;
      @(posedge clk);
      #2;
      reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      ex_rd = rd; ex_mem_read = mr; ex_branch_taken = bt; ex_jump = jp;
      mem_access = ma; dmem_ready = dr;
      f = ma && !dr;
      r = bt || jp;
      l = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e.chk_regs = m_valid;
      e.st = m_state; e.sc = m_stall; e.fc = m_flush; e.to = m_to;
      // comb packing: pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_flush, holds
      if (rst) begin
         e.comb = 7'b0001100;
         m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
         m_valid = 1;
      end else if (f) begin
         e.comb = 7'b0000011;
         m_state = 2;
         if (m_stall < CNT_MAX) m_stall++;
         if (m_wait == TIMEOUT) m_to = 1;
         else m_wait++;
      end else if (r) begin
         e.comb = 7'b1101100;
         m_state = 3;
         if (m_flush < CNT_MAX) m_flush++;
         m_wait = 0;
      end else if (l) begin
         e.comb = 7'b0000100;
         m_state = 1;
         if (m_stall < CNT_MAX) m_stall++;
         m_wait = 0;
      end else begin
         e.comb = 7'b1010000;
         m_state = 0;
         m_wait = 0;
      end
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("ctrl_outputs",
                     int'({pc_write, pc_sel_target, if_id_write, if_id_flush,
                           id_ex_flush, id_ex_hold, ex_mem_hold}), int'(e.comb));
         if (e.chk_regs) begin
            checkOutput("state", int'(state), e.st);
            checkOutput("stall_cnt", int'(stall_cnt), e.sc);
            checkOutput("flush_cnt", int'(flush_cnt), e.fc);
            checkOutput("mem_timeout", int'(mem_timeout), e.to);
         end
      end
   end

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use on rs1, then x0 load and unused rs2 match
      applyStimulus(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
      idle(1);
      applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 7, 1, 0, 7, 1, 0, 0, 0, 0);
      applyStimulus(0, 3, 7, 0, 1, 7, 1, 0, 0, 0, 0);
      idle(1);
      // taken branch with a simultaneous load-use match, then a jump
      applyStimulus(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(1);
      // three-cycle memory wait with a pending branch, then ready same cycle
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(1);
      // timeout: six freeze cycles, flag stays until reset
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(3);
      // reset mid-freeze
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(1);
      // saturation: twenty load-use cycles
      for (int i = 0; i < 20; i++) applyStimulus(0, 9, 0, 1, 0, 9, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // randomized traffic with small register numbers to provoke matches
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 59) == 0,
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                       1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
      end
      idle(2);
      repeat (4) @(negedge clk);
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end
      if (compared == 0) begin
         mismatched++;
         $display("[TB] FAIL activity: 0 comparisons, expected more");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
